// File: rtl/syn_pc_btb.sv
// Fetch-stage PC with a direct-mapped BTB and per-entry saturating direction counters.
module syn_pc_btb #(
   parameter int unsigned       ADDR_W   = 10,
   parameter int unsigned       IDX_W    = 4,
   parameter int unsigned       CNT_W    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              stall,
   input  logic              flush_btb,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_taken,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_4,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target
);

   localparam int unsigned      TAG_W   = ADDR_W - IDX_W;
   localparam int unsigned      ENTRIES = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [ADDR_W-1:0]  tgt_q [ENTRIES];
   logic [CNT_W-1:0]   cnt_q [ENTRIES];

   logic [IDX_W-1:0]  rd_idx, wr_idx;
   logic [TAG_W-1:0]  rd_tag, wr_tag;
   logic              hit_c, taken_c, upd_hit_c, wr_en_c;
   logic [ADDR_W-1:0] pc_4_c, target_c, wr_tgt_c;
   logic [CNT_W-1:0]  wr_cnt_c;

   assign rd_idx = pc_q[IDX_W-1:0];
   assign rd_tag = pc_q[ADDR_W-1:IDX_W];
   assign wr_idx = upd_pc[IDX_W-1:0];
   assign wr_tag = upd_pc[ADDR_W-1:IDX_W];

   // Zero-latency lookup and next-PC prediction from the current PC.
   always_comb begin
      pc_4_c   = pc_q + ADDR_W'(1);
      hit_c    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      taken_c  = hit_c && cnt_q[rd_idx][CNT_W-1];
      target_c = taken_c ? tgt_q[rd_idx] : pc_4_c;
   end

   // Next PC: enable gates everything, redirect beats stall, otherwise follow prediction.
   always_comb begin
      pc_d = pc_q;
      if (en) begin
         if (redirect)    pc_d = redirect_pc;
         else if (!stall) pc_d = target_c;
      end
   end

   // Training: strengthen/weaken on tag hit, allocate only on a taken miss.
   always_comb begin
      wr_en_c   = 1'b0;
      upd_hit_c = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
      wr_cnt_c  = cnt_q[wr_idx];
      wr_tgt_c  = tgt_q[wr_idx];
      if (upd_hit_c) begin
         wr_en_c = 1'b1;
         if (upd_taken) begin
            wr_tgt_c = upd_target;
            if (cnt_q[wr_idx] != CNT_MAX) wr_cnt_c = cnt_q[wr_idx] + CNT_W'(1);
         end else if (cnt_q[wr_idx] != '0) begin
            wr_cnt_c = cnt_q[wr_idx] - CNT_W'(1);
         end
      end else if (upd_taken) begin
         wr_en_c  = 1'b1;
         wr_cnt_c = CNT_WT;
         wr_tgt_c = upd_target;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   // BTB storage; flush takes precedence over a same-cycle update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         tag_q   <= '{default: '0};
         tgt_q   <= '{default: '0};
         cnt_q   <= '{default: CNT_WNT};
      end else if (en) begin
         if (flush_btb) begin
            valid_q <= '0;
         end else if (upd_valid && wr_en_c) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= wr_tgt_c;
            cnt_q[wr_idx]   <= wr_cnt_c;
         end
      end
   end

   assign pc          = pc_q;
   assign pc_4        = pc_4_c;
   assign pred_hit    = hit_c;
   assign pred_taken  = taken_c;
   assign pred_target = target_c;

endmodule

// File: tb/tb_syn_pc_btb.sv
// Bench for syn_pc_btb: directed scenarios plus randomized run against a behavioural model.
module tb_syn_pc_btb;

   localparam int AW   = 1024;
   localparam int NE   = 16;
   localparam int CMAX = 3;
   localparam int HALF = 2;

   logic       clk = 1'b0;
   logic       rst_n, en, stall, flush_btb, redirect, upd_valid, upd_taken;
   logic [9:0] redirect_pc, upd_pc, upd_target;
   logic [9:0] pc, pc_4, pred_target;
   logic       pred_hit, pred_taken;

   int tests_run = 0;
   int tests_failed = 0;

   int m_pc;
   int m_valid [NE];
   int m_tag   [NE];
   int m_tgt   [NE];
   int m_cnt   [NE];

   always #5 clk = ~clk;

   syn_pc_btb dut (
      .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush_btb(flush_btb),
      .redirect(redirect), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
      .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
      .pc(pc), .pc_4(pc_4), .pred_hit(pred_hit), .pred_taken(pred_taken),
      .pred_target(pred_target)
   );

   // Reference model: BTB as plain integer tables indexed by pc mod NE, tagged by pc / NE.
   function automatic void model_reset();
      m_pc = 0;
      for (int k = 0; k < NE; k++) begin
         m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = HALF - 1;
      end
   endfunction

   function automatic int m_hit();
      return (m_valid[m_pc % NE] != 0 && m_tag[m_pc % NE] == m_pc / NE) ? 1 : 0;
   endfunction

   function automatic int m_taken();
      return (m_hit() != 0 && m_cnt[m_pc % NE] >= HALF) ? 1 : 0;
   endfunction

   function automatic int m_target();
      return (m_taken() != 0) ? m_tgt[m_pc % NE] : (m_pc + 1) % AW;
   endfunction

   function automatic void model_apply();
      int nxt, i, t;
      if (en !== 1'b1) return;
      nxt = m_target();
      if (redirect)    m_pc = int'(redirect_pc);
      else if (!stall) m_pc = nxt;
      if (flush_btb) begin
         for (int k = 0; k < NE; k++) m_valid[k] = 0;
      end else if (upd_valid) begin
         i = int'(upd_pc) % NE;
         t = int'(upd_pc) / NE;
         if (m_valid[i] != 0 && m_tag[i] == t) begin
            if (upd_taken) begin
               m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
               m_tgt[i] = int'(upd_target);
            end else begin
               m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
         end else if (upd_taken) begin
            m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = int'(upd_target); m_cnt[i] = HALF;
         end
      end
   endfunction

   task automatic idle();
      en = 1'b1; stall = 1'b0; flush_btb = 1'b0; redirect = 1'b0; redirect_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
   endtask

   // One clock: advance the model with the held inputs, then land on the next falling edge.
   task automatic step();
      model_apply();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      tests_run++;
      if (pc !== 10'd0) begin tests_failed++; $display("FAIL reset_pc got %0d want 0", pc); end
      tests_run++;
      if (pred_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit got %0b want 0", pred_hit); end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (pc !== 10'(i) || pred_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL seq_pc cycle %0d got pc=%0d hit=%0b want pc=%0d hit=0", i, pc, pred_hit, i);
         end
         step();
      end
   endtask

   task automatic test_train_taken();
      idle();
      redirect = 1'b1; redirect_pc = 10'd3;
      upd_valid = 1'b1; upd_pc = 10'd3; upd_target = 10'd40; upd_taken = 1'b1;
      step();
      idle();
      tests_run++;
      if (pc !== 10'd3 || pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 10'd40) begin
         tests_failed++;
         $display("FAIL train_taken got pc=%0d hit=%0b tk=%0b tgt=%0d want 3 1 1 40",
                  pc, pred_hit, pred_taken, pred_target);
      end
      step();
      tests_run++;
      if (pc !== 10'd40) begin tests_failed++; $display("FAIL follow_target got %0d want 40", pc); end
   endtask

   task automatic train_pc3(input logic taken, input int n);
      idle();
      stall = 1'b1;
      upd_valid = 1'b1; upd_pc = 10'd3; upd_target = 10'd40; upd_taken = taken;
      for (int i = 0; i < n; i++) step();
      idle();
      redirect = 1'b1; redirect_pc = 10'd3;
      step();
      idle();
   endtask

   task automatic test_counter_sat();
      train_pc3(1'b0, 3);
      tests_run++;
      if (pc !== 10'd3 || pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 10'd4) begin
         tests_failed++;
         $display("FAIL nt_sat got pc=%0d hit=%0b tk=%0b tgt=%0d want 3 1 0 4",
                  pc, pred_hit, pred_taken, pred_target);
      end
      step();
      tests_run++;
      if (pc !== 10'd4) begin tests_failed++; $display("FAIL nt_fallthrough got %0d want 4", pc); end
      // one taken from a floor of 0 must stay weakly not-taken
      train_pc3(1'b1, 1);
      tests_run++;
      if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL floor_sat got tk=%0b want 0", pred_taken); end
      // four takens saturate high, one not-taken keeps it taken
      train_pc3(1'b1, 4);
      train_pc3(1'b0, 1);
      tests_run++;
      if (pred_taken !== 1'b1 || pred_target !== 10'd40) begin
         tests_failed++;
         $display("FAIL ceil_sat got tk=%0b tgt=%0d want 1 40", pred_taken, pred_target);
      end
   endtask

   task automatic test_stall_redirect();
      idle();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 10'd100;
      step();
      tests_run++;
      if (pc !== 10'd100) begin tests_failed++; $display("FAIL redirect_over_stall got %0d want 100", pc); end
      redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         tests_run++;
         if (pc !== 10'd100) begin tests_failed++; $display("FAIL stall_hold got %0d want 100", pc); end
      end
      idle();
      step();
      tests_run++;
      if (pc !== 10'd101) begin tests_failed++; $display("FAIL stall_release got %0d want 101", pc); end
   endtask

   task automatic test_alias();
      idle();
      upd_valid = 1'b1; upd_pc = 10'h013; upd_target = 10'h055; upd_taken = 1'b1;
      redirect = 1'b1; redirect_pc = 10'h023;
      step();
      idle();
      tests_run++;
      if (pc !== 10'h023 || pred_hit !== 1'b0 || pred_target !== 10'h024) begin
         tests_failed++;
         $display("FAIL alias got pc=%0h hit=%0b tgt=%0h want 23 0 24", pc, pred_hit, pred_target);
      end
      redirect = 1'b1; redirect_pc = 10'h013;
      step();
      idle();
      tests_run++;
      if (pred_hit !== 1'b1 || pred_target !== 10'h055) begin
         tests_failed++;
         $display("FAIL alias_owner got hit=%0b tgt=%0h want 1 55", pred_hit, pred_target);
      end
   endtask

   task automatic test_flush_en_rst();
      idle();
      flush_btb = 1'b1; upd_valid = 1'b1; upd_pc = 10'h013; upd_target = 10'h066; upd_taken = 1'b1;
      redirect = 1'b1; redirect_pc = 10'h013;
      step();
      idle();
      tests_run++;
      if (pred_hit !== 1'b0) begin tests_failed++; $display("FAIL flush_wins got hit=%0b want 0", pred_hit); end
      redirect = 1'b1; redirect_pc = 10'h003;
      step();
      idle();
      tests_run++;
      if (pred_hit !== 1'b0) begin tests_failed++; $display("FAIL flush_all got hit=%0b want 0", pred_hit); end
      upd_valid = 1'b1; upd_pc = 10'h013; upd_target = 10'h055; upd_taken = 1'b1;
      redirect = 1'b1; redirect_pc = 10'h013;
      step();
      en = 1'b0; flush_btb = 1'b1; redirect = 1'b1; redirect_pc = 10'd200; upd_target = 10'h077;
      step();
      step();
      tests_run++;
      if (pc !== 10'h013 || pred_hit !== 1'b1 || pred_target !== 10'h055) begin
         tests_failed++;
         $display("FAIL en_freeze got pc=%0h hit=%0b tgt=%0h want 13 1 55", pc, pred_hit, pred_target);
      end
      idle();
      step();
      tests_run++;
      if (pc !== 10'h055) begin tests_failed++; $display("FAIL en_resume got %0h want 55", pc); end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      tests_run++;
      if (pc !== 10'd0 || pred_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_rst got pc=%0d hit=%0b want 0 0", pc, pred_hit);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      tests_run++;
      if (pc !== 10'd1 || pred_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_rst got pc=%0d hit=%0b want 1 0", pc, pred_hit);
      end
   endtask

   task automatic test_wrap();
      idle();
      redirect = 1'b1; redirect_pc = 10'h3FF;
      step();
      idle();
      tests_run++;
      if (pc_4 !== 10'd0 || pred_target !== 10'd0) begin
         tests_failed++;
         $display("FAIL wrap got pc_4=%0d tgt=%0d want 0 0", pc_4, pred_target);
      end
      step();
      tests_run++;
      if (pc !== 10'd0) begin tests_failed++; $display("FAIL wrap_pc got %0d want 0", pc); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         en          = ($urandom_range(0, 9) != 0);
         stall       = ($urandom_range(0, 5) == 0);
         flush_btb   = ($urandom_range(0, 39) == 0);
         redirect    = ($urandom_range(0, 7) == 0);
         redirect_pc = 10'($urandom_range(0, 63));
         upd_valid   = ($urandom_range(0, 2) != 0);
         upd_pc      = ($urandom_range(0, 1) != 0) ? 10'(m_pc) : 10'($urandom_range(0, 63));
         upd_target  = 10'($urandom_range(0, 63));
         upd_taken   = ($urandom_range(0, 2) != 0);
         step();
         tests_run++;
         if (pc !== 10'(m_pc) || pc_4 !== 10'((m_pc + 1) % AW) || pred_hit !== 1'(m_hit()) ||
             pred_taken !== 1'(m_taken()) || pred_target !== 10'(m_target())) begin
            tests_failed++;
            $display("FAIL random cyc %0d got pc=%0d p4=%0d hit=%0b tk=%0b tgt=%0d want %0d %0d %0d %0d %0d",
                     c, pc, pc_4, pred_hit, pred_taken, pred_target,
                     m_pc, (m_pc + 1) % AW, m_hit(), m_taken(), m_target());
         end
      end
   endtask

   initial begin
      test_reset();
      test_train_taken();
      test_counter_sat();
      test_stall_redirect();
      test_alias();
      test_flush_en_rst();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
